// File: rtl/rom_port_arbiter.sv
// Two-port arbiter (fetch / load-store) sharing one combinational instruction-ROM read port.
// Define ROM_ARB_RR_EN for round-robin arbitration; default is ls priority with starvation relief.
module rom_port_arbiter #(
   parameter int unsigned ROM_SIZE   = 256,
   parameter logic [63:0] ROM_START  = 64'h0,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        if_req,
   input  logic [63:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [63:0] if_rdata,
   output logic        if_err,
   input  logic        ls_req,
   input  logic [63:0] ls_addr,
   output logic        ls_gnt,
   output logic        ls_rvalid,
   output logic [63:0] ls_rdata,
   output logic        ls_err,
   output logic [63:0] rom_haddr,
   input  logic [63:0] rom_hrdata
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   localparam logic [63:0] LAST_OFS = 64'(ROM_SIZE - 9);

   state_t      state, state_nx;
   logic        any_req, pick_ls;
   logic        owner_ls, ok_q;
   logic [63:0] addr_q, win_addr;

   // Range test works on the offset so addresses near 2^64 cannot wrap into range.
   function automatic logic in_range(input logic [63:0] a);
      logic [63:0] ofs;
      ofs = a - ROM_START;
      return (a >= ROM_START) && (ofs <= LAST_OFS);
   endfunction

`ifdef ROM_ARB_RR_EN
   logic last_ls;
`else
   localparam int unsigned CW = $clog2(STARVE_MAX + 1);
   logic [CW-1:0] starve_cnt;
`endif

   always_comb begin
      any_req = if_req | ls_req;
`ifdef ROM_ARB_RR_EN
      pick_ls = ls_req & (~if_req | ~last_ls);
`else
      pick_ls = ls_req & (~if_req | (starve_cnt != CW'(STARVE_MAX)));
`endif
      win_addr = pick_ls ? ls_addr : if_addr;
   end

   always_ff @(posedge HCLK) begin
      if (!HRESETn) state <= IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (any_req) state_nx = ACCESS;
         ACCESS:  state_nx = RESP;
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      if_gnt    = 1'b0;
      ls_gnt    = 1'b0;
      if_rvalid = 1'b0;
      ls_rvalid = 1'b0;
      if_err    = 1'b0;
      ls_err    = 1'b0;
      rom_haddr = ROM_START;
      unique case (state)
         ACCESS: begin
            if_gnt = ~owner_ls;
            ls_gnt = owner_ls;
            if (ok_q) rom_haddr = addr_q;
         end
         RESP: begin
            if_rvalid = ~owner_ls;
            ls_rvalid = owner_ls;
            if_err    = ~owner_ls & ~ok_q;
            ls_err    = owner_ls & ~ok_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         owner_ls   <= 1'b0;
         ok_q       <= 1'b0;
         addr_q     <= ROM_START;
         if_rdata   <= '0;
         ls_rdata   <= '0;
`ifdef ROM_ARB_RR_EN
         last_ls    <= 1'b1;
`else
         starve_cnt <= '0;
`endif
      end else begin
         if (state == IDLE && any_req) begin
            owner_ls <= pick_ls;
            addr_q   <= win_addr;
            ok_q     <= in_range(win_addr);
`ifdef ROM_ARB_RR_EN
            last_ls  <= pick_ls;
`else
            if (!pick_ls)               starve_cnt <= '0;
            else if (if_req && ls_req)  starve_cnt <= starve_cnt + 1'b1;
`endif
         end
         if (state == ACCESS) begin
            if (owner_ls) ls_rdata <= ok_q ? rom_hrdata : '0;
            else          if_rdata <= ok_q ? rom_hrdata : '0;
         end
      end
   end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Bench for rom_port_arbiter: directed literal checks plus randomized traffic against a
// transaction-level schedule model (grant/response/data predicted per clock edge).
module tb_rom_port_arbiter;

   localparam int unsigned RSZ = 256;
   localparam logic [63:0] RS  = 64'h0;
   localparam int unsigned SMAX = 4;
   localparam int NE = 2600;

   logic        HCLK = 1'b0;
   logic        HRESETn = 1'b0;
   logic        if_req = 1'b0, ls_req = 1'b0;
   logic [63:0] if_addr = '0, ls_addr = '0;
   logic        if_gnt, if_rvalid, if_err, ls_gnt, ls_rvalid, ls_err;
   logic [63:0] if_rdata, ls_rdata, rom_haddr, rom_hrdata;

   rom_port_arbiter #(.ROM_SIZE(RSZ), .ROM_START(RS), .STARVE_MAX(SMAX)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
      .if_rdata(if_rdata), .if_err(if_err),
      .ls_req(ls_req), .ls_addr(ls_addr), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid),
      .ls_rdata(ls_rdata), .ls_err(ls_err),
      .rom_haddr(rom_haddr), .rom_hrdata(rom_hrdata)
   );

   always #5 HCLK = ~HCLK;

   logic [7:0] rom [RSZ];
   always_comb begin
      rom_hrdata = '0;
      for (int i = 0; i < 8; i++) rom_hrdata[i*8 +: 8] = rom[(int'(rom_haddr[7:0]) + i) % RSZ];
   end

   int tests = 0;
   int fails = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   // Expected outputs indexed by number of clock edges completed.
   typedef struct {
      bit gi, gl, ri, rl, ei, el, ui, ul;
      logic [63:0] haddr, vi, vl;
   } exp_t;
   exp_t ex [NE];
   int edges = 0;
   int next_arb = 0;
   int cnt = 0;
   bit last_ls = 1'b1;

   initial for (int i = 0; i < NE; i++) begin
      ex[i] = '{default: '0};
      ex[i].haddr = RS;
   end

   function automatic logic [63:0] rom_word(input logic [63:0] a);
      logic [63:0] v = '0;
      for (int i = 0; i < 8; i++) v = v | (64'(rom[int'(a - RS) + i]) << (8 * i));
      return v;
   endfunction

   always @(posedge HCLK) begin
      int e;
      bit win_ls, ok;
      logic [63:0] a;
      edges++;
      e = edges;
      if (e + 2 < NE) begin
         if (!HRESETn) begin
            for (int i = e; i <= e + 2; i++) begin
               ex[i] = '{default: '0};
               ex[i].haddr = RS;
            end
            ex[e].ui = 1; ex[e].ul = 1;
            cnt = 0; last_ls = 1'b1;
            next_arb = e + 1;
         end else if (e >= next_arb && (if_req || ls_req)) begin
`ifdef ROM_ARB_RR_EN
            win_ls = (if_req && ls_req) ? !last_ls : ls_req;
            last_ls = win_ls;
`else
            if (if_req && ls_req) begin
               if (cnt == SMAX) begin win_ls = 0; cnt = 0; end
               else begin win_ls = 1; cnt++; end
            end else begin
               win_ls = ls_req;
               if (!win_ls) cnt = 0;
            end
`endif
            a  = win_ls ? ls_addr : if_addr;
            ok = (a >= RS) && (a - RS < 64'(RSZ - 8));
            ex[e].gi = !win_ls; ex[e].gl = win_ls;
            ex[e].haddr = ok ? a : RS;
            ex[e+1].ri = !win_ls; ex[e+1].rl = win_ls;
            ex[e+1].ei = !win_ls && !ok; ex[e+1].el = win_ls && !ok;
            if (win_ls) begin ex[e+1].ul = 1; ex[e+1].vl = ok ? rom_word(a) : '0; end
            else        begin ex[e+1].ui = 1; ex[e+1].vi = ok ? rom_word(a) : '0; end
            next_arb = e + 3;
         end
      end
   end

   logic [63:0] m_if = '0, m_ls = '0;
   always @(negedge HCLK) begin
      int k;
      k = edges;
      if (k >= 1 && k < NE) begin
         if (ex[k].ui) m_if = ex[k].vi;
         if (ex[k].ul) m_ls = ex[k].vl;
         chk("if_gnt",    64'(if_gnt),    64'(ex[k].gi));
         chk("ls_gnt",    64'(ls_gnt),    64'(ex[k].gl));
         chk("if_rvalid", 64'(if_rvalid), 64'(ex[k].ri));
         chk("ls_rvalid", 64'(ls_rvalid), 64'(ex[k].rl));
         chk("if_err",    64'(if_err),    64'(ex[k].ei));
         chk("ls_err",    64'(ls_err),    64'(ex[k].el));
         chk("rom_haddr", rom_haddr, ex[k].haddr);
         chk("if_rdata",  if_rdata, m_if);
         chk("ls_rdata",  ls_rdata, m_ls);
      end
   end

   task automatic do_req(input bit use_ls, input logic [63:0] a, output int lat,
                         output logic rv, output logic [63:0] rd, output logic er,
                         output logic [63:0] ha);
      bit got = 0;
      lat = 0; ha = '1;
      if (use_ls) begin ls_req = 1; ls_addr = a; end
      else        begin if_req = 1; if_addr = a; end
      for (int i = 1; i <= 20 && !got; i++) begin
         @(negedge HCLK);
         if (use_ls ? ls_gnt : if_gnt) begin got = 1; lat = i; ha = rom_haddr; end
      end
      if_req = 0; ls_req = 0;
      @(negedge HCLK);
      rv = use_ls ? ls_rvalid : if_rvalid;
      rd = use_ls ? ls_rdata : if_rdata;
      er = use_ls ? ls_err : if_err;
      @(negedge HCLK);
   endtask

   function automatic logic [63:0] pick_addr();
      int s = $urandom_range(0, 9);
      if (s <= 5) return 64'($urandom_range(0, 247));
      if (s == 6) return 64'($urandom_range(247, 248));
      if (s == 7) return 64'($urandom_range(249, 300));
      if (s == 8) return {$urandom, $urandom};
      return 64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 7));
   endfunction

   initial begin
      int lat, n;
      logic rv, er;
      logic [63:0] rd, ha;
      logic [9:0] order, exp_order;
      bit pi, pl;
      logic [7:0] pre [12];
      pre = '{8'h93, 8'h00, 8'h80, 8'h3e, 8'h6f, 8'h02, 8'h80, 8'h00, 8'h13, 8'h81, 8'h00, 8'h7d};
      for (int i = 0; i < int'(RSZ); i++) rom[i] = (i < 12) ? pre[i] : 8'($urandom);

      repeat (3) @(negedge HCLK);
      chk("reset_if_rdata", if_rdata, 64'h0);
      chk("reset_haddr", rom_haddr, RS);
      HRESETn = 1;
      @(negedge HCLK);

      do_req(0, 64'd0, lat, rv, rd, er, ha);
      chk("t1_gnt_latency", 64'(lat), 64'd1);
      chk("t1_rvalid", 64'(rv), 64'd1);
      chk("t1_rdata", rd, 64'h0080_026f_3e80_0093);
      chk("t1_err", 64'(er), 64'd0);
      do_req(1, 64'd4, lat, rv, rd, er, ha);
      chk("t2_rvalid", 64'(rv), 64'd1);
      chk("t2_rdata", rd, 64'h7d00_8113_0080_026f);
      chk("t2_err", 64'(er), 64'd0);
      chk("t2_haddr", ha, 64'd4);
      do_req(1, 64'd247, lat, rv, rd, er, ha);
      chk("t3_247_err", 64'(er), 64'd0);
      chk("t3_247_haddr", ha, 64'd247);
      do_req(1, 64'd248, lat, rv, rd, er, ha);
      chk("t3_248_err", 64'(er), 64'd1);
      chk("t3_248_rdata", rd, 64'h0);
      chk("t3_248_haddr", ha, RS);
      do_req(1, 64'hFFFF_FFFF_FFFF_FFF8, lat, rv, rd, er, ha);
      chk("t3_top_err", 64'(er), 64'd1);
      chk("t3_top_rdata", rd, 64'h0);
      chk("t3_top_haddr", ha, RS);

      HRESETn = 0;
      @(negedge HCLK);
      HRESETn = 1;
      if_req = 1; if_addr = 64'd0; ls_req = 1; ls_addr = 64'd8;
      n = 0; order = '0;
      for (int i = 0; i < 80 && n < 10; i++) begin
         @(negedge HCLK);
         if (if_gnt || ls_gnt) begin order[9 - n] = ls_gnt; n++; end
      end
      HRESETn = 0; if_req = 0; ls_req = 0;
      @(negedge HCLK);
      HRESETn = 1;
`ifdef ROM_ARB_RR_EN
      exp_order = 10'b0101010101;
`else
      exp_order = 10'b1111011110;
`endif
      chk("t4_grant_count", 64'(n), 64'd10);
      chk("t4_grant_order", 64'(order), 64'(exp_order));

      do_req(0, 64'd0, lat, rv, rd, er, ha);
      if_req = 1; if_addr = 64'd0;
      n = 0;
      for (int i = 0; i < 20 && n == 0; i++) begin
         @(negedge HCLK);
         if (if_gnt) n = 1;
      end
      chk("t5_gnt_seen", 64'(n), 64'd1);
      HRESETn = 0; if_req = 0;
      @(negedge HCLK);
      HRESETn = 1;
      chk("t5_if_rvalid", 64'(if_rvalid), 64'd0);
      chk("t5_ls_rvalid", 64'(ls_rvalid), 64'd0);
      chk("t5_if_rdata", if_rdata, 64'h0);
      chk("t5_haddr", rom_haddr, RS);
      @(negedge HCLK);
      chk("t5_if_rvalid_late", 64'(if_rvalid), 64'd0);

      pi = 0; pl = 0;
      for (int c = 0; c < 1800; c++) begin
         @(negedge HCLK);
         HRESETn = 1;
         if (pi && if_gnt) pi = 0;
         if (pl && ls_gnt) pl = 0;
         if (!pi) begin
            if_req = ($urandom_range(0, 2) != 0);
            if_addr = pick_addr();
            pi = if_req;
         end
         if (!pl) begin
            ls_req = ($urandom_range(0, 2) != 0);
            ls_addr = pick_addr();
            pl = ls_req;
         end
         if ($urandom_range(0, 149) == 0) HRESETn = 0;
      end
      if_req = 0; ls_req = 0;
      repeat (4) @(negedge HCLK);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
